pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle controller that owns the architectural PC register for the sequential RISC-V core.
- Sequences each instruction through fetch, execute and PC update.
- Fetch uses a req/ready handshake with instruction memory.
- PC update takes the branch decision (branch AND zero) from the datapath and selects the target or PC+4.
- Traps on a misaligned target or a fetch timeout. Counts retired instructions.

Parameters:
- XLEN, 64, width of PC, target and retire counter.
- RESET_PC, 64'h0, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum FETCH cycles waiting for imem_ready before trapping; legal range 2..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request, high throughout FETCH.
- imem_addr  out  XLEN  fetch address, equals pc.
- imem_ready  in  1  instruction data valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction, stable through EXEC.
- instr_valid  out  1  high while in EXEC.
- ex_done  in  1  datapath finished executing the current instruction.
- stall  in  1  datapath hold request.
- branch  in  1  instruction is a taken-if-zero branch.
- zero  in  1  ALU zero flag.
- target  in  XLEN  branch target address.
- halt  in  1  stop after the current instruction retires.
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN.
- trap  out  1  sticky error indication.
- trap_cause  out  2  01 misaligned target, 10 fetch timeout, 00 none.
- halted  out  1  high in HALTED.
- retired  out  XLEN  retired instruction count.

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc=RESET_PC; state=IDLE; instr=0; retired=0; trap=0; trap_cause=00; timeout counter=0.
  - All handshake outputs low.
  - Applies mid-handshake: imem_req drops the cycle after the reset edge; an in-flight fetch is discarded.
- States:
  - IDLE
  - FETCH
  - EXEC
  - UPDATE
  - HALTED
  - TRAP
- IDLE: one cycle, then FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, go to EXEC, timeout counter cleared.
  - Otherwise the counter increments. When the counter reaches FETCH_TIMEOUT-1 without imem_ready: go to TRAP with cause 10.
  - imem_ready outside FETCH is ignored.
- EXEC:
  - instr_valid=1.
  - ex_done is sampled only when stall=0.
  - ex_done=1 and stall=0: go to UPDATE, latching branch, zero and target that cycle.
  - stall=1 holds EXEC regardless of ex_done.
- UPDATE (one cycle):
  - taken = branch & zero; next = taken ? target : pc_plus4.
  - If taken and target[1:0] != 00: TRAP, cause 01. pc is unchanged and retired is not incremented.
  - Otherwise pc<=next and retired<=retired+1. Then go to HALTED if halt=1, else FETCH.
  - Latency: 1 cycle from the ex_done acceptance edge to the pc update edge.
- HALTED: all outputs hold and imem_req=0. Only reset exits.
- TRAP: trap=1 and trap_cause hold, imem_req=0, pc holds the faulting-instruction PC. Only reset exits.
- Arithmetic wrap-around:
  - pc_plus4 wraps, e.g. pc=64'hFFFF_FFFF_FFFF_FFFC gives 0.
  - retired wraps modulo 2^XLEN.
- halt outside UPDATE has no effect until the next UPDATE. Sampling happens only in UPDATE.
- Bench-visible:
  - pc changes only on an UPDATE edge or on reset.
  - imem_req and instr_valid are never high together.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum (IDLE, FETCH, EXEC, UPDATE, HALTED, TRAP).
  - trap cause constants CAUSE_NONE=00, CAUSE_MISALIGN=01, CAUSE_TIMEOUT=10.
  - PC_INCR=4.
- One natural sub-module, pc_next_sel: combinational pc_plus4 and taken/target selection plus the alignment check. It is instantiated once.
- The FSM, PC register, timeout counter and retire counter stay in the top level.

Test Plan:
- Reset, then imem_ready=1 on the 2nd FETCH cycle, ex_done with branch=0 -> pc 0->4, retired=1, state back to FETCH with imem_addr=4.
- pc=8, branch=1, zero=1, target=0x100 -> pc=0x100. Repeat with zero=0 -> pc=0xC.
- stall=1 with ex_done=1 for 3 cycles, then stall=0 -> UPDATE only on the first unstalled cycle; pc unchanged during the stall.
- Taken branch with target=0x102 -> trap=1, cause=01, pc stays at the old value, imem_req=0 forever until rst_n=0.
- imem_ready held low with FETCH_TIMEOUT=16 -> TRAP with cause=10 exactly 16 cycles after FETCH entry. rst_n low mid-FETCH -> next cycle pc=RESET_PC, imem_req=0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, non-branch instruction with halt=1 in UPDATE -> pc=0, retired=1, halted=1, no further imem_req.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, trap causes
// and the sequential PC increment.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        UPDATE,
        HALTED,
        TRAP
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential PC+4 or a taken branch target, plus the
// alignment check that only applies when the branch is actually taken.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic taken;

    assign pc_plus4   = pc + XLEN'(PC_INCR);
    assign taken      = branch & zero;
    assign next_pc    = taken ? target : pc_plus4;
    assign misaligned = taken && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle sequencer owning the architectural PC: fetch handshake, execute
// wait, PC update, retire counting, and sticky traps on timeout/misalignment.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN          = 64,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            ex_done,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] target,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic            halted,
    output logic [XLEN-1:0] retired
);

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t          state, state_next;
    logic [7:0]      fetch_cnt;
    logic            branch_q, zero_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            fetch_expired;
    logic            ex_accept;

    assign fetch_expired = (state == FETCH) && !imem_ready && (fetch_cnt == CNT_LAST);
    assign ex_accept     = ex_done && !stall;

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);

    // Branch inputs are captured at ex_done acceptance so UPDATE sees a stable decision.
    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .pc         (pc),
        .branch     (branch_q),
        .zero       (zero_q),
        .target     (target_q),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH: begin
                if (imem_ready)         state_next = EXEC;
                else if (fetch_expired) state_next = TRAP;
            end
            EXEC:   if (ex_accept) state_next = UPDATE;
            UPDATE: begin
                if (misaligned) state_next = TRAP;
                else if (halt)  state_next = HALTED;
                else            state_next = FETCH;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= '0;
            retired    <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            fetch_cnt  <= '0;
            branch_q   <= 1'b0;
            zero_q     <= 1'b0;
            target_q   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr     <= imem_rdata;
                        fetch_cnt <= '0;
                    end else if (fetch_expired) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 8'd1;
                    end
                end
                EXEC: begin
                    if (ex_accept) begin
                        branch_q <= branch;
                        zero_q   <= zero;
                        target_q <= target;
                    end
                end
                UPDATE: begin
                    if (misaligned) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_MISALIGN;
                    end else begin
                        pc      <= next_pc;
                        retired <= retired + XLEN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver predicts each retire/trap event
// from a PC/retire-count model; an independent monitor compares observed events.
module tb_pc_sequencer;

    localparam int              XLEN   = 64;
    localparam int              TMO    = 16;
    localparam logic [XLEN-1:0] RST_PC = '0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            ex_done = 1'b0;
    logic            stall = 1'b0;
    logic            branch = 1'b0;
    logic            zero = 1'b0;
    logic [XLEN-1:0] target = '0;
    logic            halt = 1'b0;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            trap;
    logic [1:0]      trap_cause;
    logic            halted;
    logic [XLEN-1:0] retired;

    pc_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .ex_done(ex_done), .stall(stall),
        .branch(branch), .zero(zero), .target(target), .halt(halt),
        .pc(pc), .pc_plus4(pc_plus4),
        .trap(trap), .trap_cause(trap_cause),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] retired;
        logic        trap;
        logic [1:0]  cause;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pc  = '0;
    logic [63:0] m_ret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic t, input logic [1:0] c, input logic h);
        exp_t e;
        e.pc = m_pc; e.retired = m_ret; e.trap = t; e.cause = c; e.halted = h;
        sb.push_back(e);
    endtask

    // Monitor: an event is a retire-count change or a trap rising edge.
    initial begin : monitor
        logic [63:0] prev_pc, prev_ret;
        logic        prev_trap;
        exp_t        e;
        prev_pc = '0; prev_ret = '0; prev_trap = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_pc = pc; prev_ret = retired; prev_trap = trap;
            end else begin
                check("req_valid_excl", 64'(imem_req & instr_valid), 64'd0);
                if (retired != prev_ret || (trap && !prev_trap)) begin
                    check("event_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("ev_pc", pc, e.pc);
                        check("ev_retired", retired, e.retired);
                        check("ev_trap", 64'(trap), 64'(e.trap));
                        check("ev_cause", 64'(trap_cause), 64'(e.cause));
                        check("ev_halted", 64'(halted), 64'(e.halted));
                    end
                end else if (pc != prev_pc) begin
                    check("pc_without_retire", pc, prev_pc);
                end
                prev_pc = pc; prev_ret = retired; prev_trap = trap;
            end
        end
    end

    task automatic do_reset(input logic ready_in_reset);
        check("sb_drained", 64'(sb.size()), 64'd0);
        rst_n = 1'b0; imem_ready = ready_in_reset; imem_rdata = $urandom;
        ex_done = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0;
        @(negedge clk);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_retired", retired, 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_cause", 64'(trap_cause), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = RST_PC; m_ret = '0;
    endtask

    task automatic wait_fetch(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("fetch_seen", 64'(ok), 64'd1);
        if (ok) check("imem_addr", imem_addr, m_pc);
    endtask

    task automatic run_instr(input int dly, input int pre, input int nstall,
                             input logic br, input logic zr,
                             input logic [63:0] tgt, input logic hlt);
        logic        ok;
        logic [31:0] word;
        logic        taken;
        wait_fetch(ok);
        if (!ok) return;
        word = $urandom;
        repeat (dly) begin
            imem_ready = 1'b0; imem_rdata = $urandom;
            @(negedge clk);
        end
        imem_ready = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0; imem_rdata = $urandom;
        check("instr_valid", 64'(instr_valid), 64'd1);
        check("instr_latch", 64'(instr), 64'(word));
        check("pc_plus4", pc_plus4, m_pc + 64'd4);
        repeat (pre) begin
            ex_done = 1'b0; stall = 1'($urandom); halt = 1'($urandom);
            branch = 1'($urandom); zero = 1'($urandom); target = {$urandom, $urandom};
            @(negedge clk);
        end
        repeat (nstall) begin
            stall = 1'b1; ex_done = 1'b1;
            branch = 1'($urandom); zero = 1'($urandom); target = {$urandom, $urandom};
            @(negedge clk);
            check("stall_hold", 64'(instr_valid), 64'd1);
            check("stall_pc", pc, m_pc);
        end
        stall = 1'b0; ex_done = 1'b1; branch = br; zero = zr; target = tgt; halt = 1'($urandom);
        @(negedge clk);
        check("update_left_exec", 64'(instr_valid), 64'd0);
        ex_done = 1'b0; branch = 1'($urandom); zero = 1'($urandom);
        target = {$urandom, $urandom}; halt = hlt;
        taken = br & zr;
        if (taken && tgt[1:0] != 2'b00) begin
            push_exp(1'b1, 2'b01, 1'b0);
        end else begin
            m_pc  = taken ? tgt : m_pc + 64'd4;
            m_ret = m_ret + 64'd1;
            push_exp(1'b0, 2'b00, hlt);
        end
        @(negedge clk);
        halt = 1'($urandom);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic        ok;
        int          n;
        logic [63:0] tgt;
        logic        br, zr;

        @(negedge clk);
        do_reset(1'b0);

        // Directed sequencing and branch selection.
        run_instr(1, 0, 0, 1'b0, 1'b0, 64'h0, 1'b0);
        run_instr(0, 1, 0, 1'b0, 1'b0, 64'h0, 1'b0);
        run_instr(2, 0, 0, 1'b1, 1'b1, 64'h100, 1'b0);
        run_instr(0, 0, 0, 1'b1, 1'b1, 64'h8, 1'b0);
        run_instr(TMO - 1, 0, 0, 1'b1, 1'b0, 64'h100, 1'b0);
        run_instr(0, 0, 0, 1'b1, 1'b0, 64'h102, 1'b0);
        run_instr(0, 0, 3, 1'b0, 1'b0, 64'h0, 1'b0);

        // Randomized program; taken targets are kept aligned so it keeps running.
        for (int i = 0; i < 40; i++) begin
            br  = 1'($urandom);
            zr  = 1'($urandom);
            tgt = {$urandom, $urandom};
            if (br && zr) tgt[1:0] = 2'b00;
            run_instr(int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), br, zr, tgt, 1'b0);
        end

        // Misaligned taken branch traps and stays put.
        run_instr(0, 0, 0, 1'b1, 1'b1, 64'h102, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("trap_no_req", 64'(imem_req), 64'd0);
            check("trap_pc_hold", pc, m_pc);
            @(negedge clk);
        end

        // Fetch timeout: trap exactly TMO cycles after FETCH entry.
        do_reset(1'b0);
        wait_fetch(ok);
        push_exp(1'b1, 2'b10, 1'b0);
        n = 0;
        for (int i = 0; i < 3 * TMO; i++) begin
            @(negedge clk);
            n++;
            if (trap) break;
        end
        check("timeout_cycles", 64'(n), 64'(TMO));
        repeat (3) @(negedge clk);
        check("timeout_no_req", 64'(imem_req), 64'd0);

        // Reset in the middle of a fetch with imem_ready asserted.
        do_reset(1'b0);
        run_instr(0, 0, 0, 1'b0, 1'b0, 64'h0, 1'b0);
        wait_fetch(ok);
        repeat (3) @(negedge clk);
        do_reset(1'b1);

        // PC wrap-around through pc_plus4 and halt sampled in UPDATE.
        run_instr(0, 0, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        run_instr(1, 0, 0, 1'b0, 1'b0, 64'h0, 1'b1);
        check("halt_pc_wrapped", pc, 64'h0);
        check("halt_flag", 64'(halted), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_no_req", 64'(imem_req), 64'd0);
            check("halt_retired_hold", retired, m_ret);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
